// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares one memory port between instruction fetch and data access.
//    Arbitrates the two requesters in IDLE, registers the winning request
//    onto the memory bus, waits a variable number of cycles for mem_ack and
//    returns read data with a one-cycle done pulse on the granted port.
//    Misaligned requests and accesses that exceed TIMEOUT wait cycles are
//    aborted and flagged with err.
//
// Ports
//    clock, reset            rising-edge clock, synchronous active-high reset
//    if_req/if_addr          fetch request (always a 32-bit load)
//    if_rdata/if_done        fetched instruction and its completion pulse
//    data_req/data_write     data request, 1 = store
//    data_size               00 byte, 01 half, 10 word, 11 dword
//    data_addr/data_wdata    data address, right-aligned store data
//    data_rdata/data_done    zero-extended load data and its completion pulse
//    err                     qualifies the done pulse: access aborted
//    mem_en/mem_we/mem_size  memory bus control, mem_en high exactly in BUSY
//    mem_addr/mem_wdata      registered address / store data
//    mem_rdata/mem_ack       memory response, ack honoured only in BUSY

module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              data_req,
   input  logic              data_write,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_done,
   output logic              err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   // Timeout counter only needs to reach TIMEOUT-1.
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [TW-1:0]     tcnt_q;
   logic [SW-1:0]     starve_q;
   logic              grant_if_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;

   logic              any_req;
   logic              grant_data;
   logic [ADDR_W-1:0] win_addr;
   logic [1:0]        win_size;
   logic              win_we;
   logic              win_misaligned;
   logic              starved;
   logic              timeout_hit;

   function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] sz);
      logic m;
      unique case (sz)
         2'b00:   m = 1'b0;
         2'b01:   m = lo[0];
         2'b10:   m = |lo[1:0];
         default: m = |lo;
      endcase
      return m;
   endfunction

   // Keeps the low 8<<sz bits; used to zero-extend load data.
   function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         m[i] = (i < (32'd8 << sz));
      end
      return m;
   endfunction

   // Arbitration: data wins unless fetch has been passed over STARVE_LIMIT times.
   always_comb begin
      starved        = if_req && (starve_q == SW'(STARVE_LIMIT));
      any_req        = if_req || data_req;
      grant_data     = data_req && !starved;
      win_addr       = grant_data ? data_addr : if_addr;
      win_size       = grant_data ? data_size : 2'b10;
      win_we         = grant_data ? data_write : 1'b0;
      win_misaligned = misaligned(win_addr[2:0], win_size);
      timeout_hit    = (tcnt_q == TW'(TIMEOUT - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_en     = 1'b0;
      if_done    = 1'b0;
      data_done  = 1'b0;
      err        = 1'b0;
      if_rdata   = '0;
      data_rdata = '0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = win_misaligned ? DONE : BUSY;
            end
         end
         BUSY: begin
            mem_en = 1'b1;
            // An ack in the expiry cycle takes priority over the abort.
            if (mem_ack || timeout_hit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            err     = err_q;
            if (grant_if_q) begin
               if_done  = 1'b1;
               if_rdata = rdata_q[31:0];
            end else begin
               data_done  = 1'b1;
               data_rdata = rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tcnt_q     <= '0;
         starve_q   <= '0;
         grant_if_q <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         mem_we     <= 1'b0;
         mem_size   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_if_q <= !grant_data;
                  tcnt_q     <= '0;
                  if (grant_data) begin
                     if (if_req && (starve_q != SW'(STARVE_LIMIT))) begin
                        starve_q <= starve_q + SW'(1);
                     end
                  end else begin
                     starve_q <= '0;
                  end
                  if (win_misaligned) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     err_q     <= 1'b0;
                     mem_we    <= win_we;
                     mem_size  <= win_size;
                     mem_addr  <= win_addr;
                     mem_wdata <= grant_data ? data_wdata : '0;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  err_q   <= 1'b0;
                  rdata_q <= mem_we ? '0 : (mem_rdata & size_mask(mem_size));
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//    Transaction-level reference: each grant is predicted from the pending
//    requests and a starvation count, and its done cycle, err and read data
//    are derived from the chosen memory latency.

module tb_mem_port_arbiter;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned TO = 4;
   localparam int unsigned SL = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [31:0]   if_rdata;
   logic          if_done;
   logic          data_req;
   logic          data_write;
   logic [1:0]    data_size;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata;
   logic [DW-1:0] data_rdata;
   logic          data_done;
   logic          err;
   logic          mem_en;
   logic          mem_we;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_LIMIT(SL)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .data_req(data_req), .data_write(data_write), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_done(data_done), .err(err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned starve  = 0;
   logic        got_if;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] trunc(input logic [63:0] v, input int unsigned bytes);
      if (bytes >= 8) return v;
      return v & ((64'd1 << (bytes * 8)) - 64'd1);
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_en"},    {63'd0, mem_en}, 64'd0);
      check({tag, "_addr"},  mem_addr, 64'd0);
      check({tag, "_wdata"}, mem_wdata, 64'd0);
      check({tag, "_wesz"},  {61'd0, mem_we, mem_size}, 64'd0);
      check({tag, "_done"},  {61'd0, if_done, data_done, err}, 64'd0);
      check({tag, "_ird"},   {32'd0, if_rdata}, 64'd0);
      check({tag, "_drd"},   data_rdata, 64'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      if_req   = 1'b0;
      data_req = 1'b0;
      mem_ack  = 1'b0;
      repeat (2) @(negedge clock);
      check_zero("rst");
      reset  = 1'b0;
      starve = 0;
   endtask

   // One cycle of IDLE; mem_ack is toggled to show it is ignored outside BUSY.
   task automatic idle_cycle();
      @(negedge clock);
      check("idle_en",   {63'd0, mem_en}, 64'd0);
      check("idle_done", {62'd0, if_done, data_done}, 64'd0);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
   endtask

   task automatic raise_if();
      if_req  = 1'b1;
      if_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
   endtask

   task automatic raise_data();
      data_req   = 1'b1;
      data_write = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 3));
      data_addr  = {$urandom, $urandom};
      data_wdata = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) data_addr[2:0] = 3'b000;
   endtask

   // Called at the negedge of an IDLE cycle with requests already driven.
   // lat = wait cycles before mem_ack (>= TO means never).
   task automatic serve(input int unsigned lat, input logic [63:0] rd, output logic seen_if);
      bit            win_data;
      logic [63:0]   a;
      int unsigned   bytes;
      bit            we;
      bit            mis;
      int unsigned   exp_done;
      int unsigned   exp_busy;
      bit            exp_err;
      logic [63:0]   exp_rd;
      int unsigned   busy;
      bit            done_seen;
      logic [1:0]    sz;

      win_data = data_req && !(if_req && starve == SL);
      if (win_data) begin
         if (if_req && starve < SL) starve++;
      end else begin
         starve = 0;
      end
      a     = win_data ? data_addr : if_addr;
      sz    = win_data ? data_size : 2'b10;
      we    = win_data ? data_write : 1'b0;
      bytes = 1 << sz;
      mis   = (a[2:0] % bytes) != 0;
      if (mis) begin
         exp_busy = 0; exp_done = 1; exp_err = 1'b1; exp_rd = '0;
      end else if (lat < TO) begin
         exp_busy = lat + 1; exp_done = lat + 2; exp_err = 1'b0;
         exp_rd = we ? 64'd0 : trunc(rd, bytes);
      end else begin
         exp_busy = TO; exp_done = TO + 1; exp_err = 1'b1; exp_rd = '0;
      end

      busy      = 0;
      done_seen = 1'b0;
      seen_if   = 1'b0;
      for (int unsigned k = 1; k <= 40 && !done_seen; k++) begin
         @(negedge clock);
         if (mem_en) begin
            busy++;
            if (busy == 1) begin
               check("mem_addr", mem_addr, a);
               check("mem_we",   {63'd0, mem_we}, {63'd0, we});
               check("mem_size", {62'd0, mem_size}, {62'd0, sz});
               if (we) check("mem_wdata", mem_wdata, data_wdata);
            end
            mem_ack   = (busy == lat + 1);
            mem_rdata = mem_ack ? rd : {$urandom, $urandom};
         end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
         end
         if (if_done || data_done) begin
            done_seen = 1'b1;
            seen_if   = if_done;
            check("done_cycle", 64'(k), 64'(exp_done));
            check("busy_cycles", 64'(busy), 64'(exp_busy));
            check("done_port", {62'd0, if_done, data_done}, win_data ? 64'd1 : 64'd2);
            check("err", {63'd0, err}, {63'd0, exp_err});
            if (win_data) check("data_rdata", data_rdata, exp_rd);
            else          check("if_rdata", {32'd0, if_rdata}, {32'd0, exp_rd[31:0]});
            if (win_data) data_req = 1'b0;
            else          if_req   = 1'b0;
            mem_ack = 1'b0;
         end
      end
      check("done_seen", {63'd0, done_seen}, 64'd1);
   endtask

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = '0; data_req = 1'b0; data_write = 1'b0;
      data_size = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      @(negedge clock);
      do_reset();

      // Zero-wait dword load
      data_req = 1'b1; data_write = 1'b0; data_size = 2'b11;
      data_addr = 64'h10; data_wdata = '0;
      serve(0, 64'h0000_0000_DEAD_BEEF, got_if);

      // Fetch with three wait cycles
      idle_cycle();
      if_req = 1'b1; if_addr = 64'h8;
      serve(3, 64'h1234_5678_8B02_0020, got_if);
      check("t3_port", {63'd0, got_if}, 64'd1);

      // Misaligned word store, then byte store at odd address
      idle_cycle();
      data_req = 1'b1; data_write = 1'b1; data_size = 2'b10;
      data_addr = 64'h6; data_wdata = 64'h55;
      serve(0, 64'h0, got_if);
      idle_cycle();
      data_req = 1'b1; data_write = 1'b1; data_size = 2'b00;
      data_addr = 64'h7; data_wdata = 64'hA5;
      serve(1, 64'hFFFF, got_if);

      // Timeout, then ack in the expiry cycle
      idle_cycle();
      data_req = 1'b1; data_write = 1'b0; data_size = 2'b11; data_addr = 64'h20;
      serve(100, 64'h1111, got_if);
      idle_cycle();
      data_req = 1'b1; data_write = 1'b0; data_size = 2'b01; data_addr = 64'h22;
      serve(TO - 1, 64'hCAFE_F00D_1234_ABCD, got_if);

      // Both ports requesting every IDLE: D,D,D,D,IF repeating
      idle_cycle();
      do_reset();
      raise_if(); if_addr[1:0] = 2'b00;
      raise_data();
      for (int i = 0; i < 10; i++) begin
         serve($urandom_range(0, 2), {$urandom, $urandom}, got_if);
         check("starve_order", {63'd0, got_if}, ((i % 5) == 4) ? 64'd1 : 64'd0);
         idle_cycle();
         if (!if_req) begin raise_if(); if_addr[1:0] = 2'b00; end
         if (!data_req) raise_data();
      end
      if_req = 1'b0; data_req = 1'b0;

      // Reset in the second BUSY cycle abandons the access
      idle_cycle();
      data_req = 1'b1; data_write = 1'b0; data_size = 2'b11; data_addr = 64'h40;
      @(negedge clock);
      check("t6_busy1", {63'd0, mem_en}, 64'd1);
      mem_ack = 1'b0;
      @(negedge clock);
      check("t6_busy2", {63'd0, mem_en}, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      check_zero("t6");
      reset = 1'b0; data_req = 1'b0; starve = 0;
      if_req = 1'b1; if_addr = 64'h100;
      serve(1, 64'h0BAD_F00D_8765_4321, got_if);

      // Randomized traffic
      for (int r = 0; r < 150; r++) begin
         idle_cycle();
         if (!if_req && $urandom_range(0, 3) != 0) raise_if();
         if (!data_req && $urandom_range(0, 3) != 0) raise_data();
         if (!if_req && !data_req) raise_data();
         serve($urandom_range(0, 5), {$urandom, $urandom}, got_if);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
